// File: rtl/ecc_pkg.sv
// Shared ECC definitions: decoder error-class encodings and the width of
// one queued result entry ({data, error class}).
package ecc_pkg;

    localparam logic [1:0] NOF_NONE   = 2'd0;  // no error
    localparam logic [1:0] NOF_SINGLE = 2'd1;  // single error corrected
    localparam logic [1:0] NOF_DOUBLE = 2'd2;  // double error detected (3 reserved)

    localparam int ECC_DATA_WIDTH = 32;
    localparam int ENTRY_WIDTH    = ECC_DATA_WIDTH + 2;

    // Entry width for an arbitrary data width: data word plus 2-bit class.
    function automatic int entry_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/ecc_result_fifo_if.sv
// Consumer-side valid/ready read port of the ECC result FIFO.
//   rd_valid : head entry present          (master -> slave)
//   rd_data  : head result word            (master -> slave)
//   rd_nof   : head error class            (master -> slave)
//   rd_ready : consumer accepts the head   (slave -> master)
interface ecc_result_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            rd_nof;

    modport master (output rd_valid, output rd_data, output rd_nof, input  rd_ready);
    modport slave  (input  rd_valid, input  rd_data, input  rd_nof, output rd_ready);
endinterface

// File: rtl/ecc_result_fifo_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter.
//   push/wr_data : write request and entry
//   pop          : read request (ignored while empty)
//   rd_data      : head entry, forced to 0 while empty
//   level/full/empty : occupancy, all derived from the registered level
//   push_ok      : the push in this cycle is accepted
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_ok
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; stale contents are hidden by the empty mask.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ecc_result_fifo.sv
// Captures each completed ECC codec result into a small FIFO and presents it
// on a valid/ready port; keeps saturating decode-outcome statistics.
//   clk, rst        : clock, synchronous active-high reset
//   done_in         : codec operation_done (rising edge = one result)
//   data_in, nof_in : codec result word and error class
//   clr_stats       : clears counters and overflow
//   rd              : read port (valid/ready, data, error class)
//   level/full/empty: FIFO occupancy
//   overflow        : sticky, a result was dropped
//   cnt_ok/cnt_corr/cnt_uncorr : saturating outcome counters
module ecc_result_fifo
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      done_in,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [1:0]                nof_in,
    input  logic                      clr_stats,
    ecc_result_fifo_if.master         rd,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic [CNT_WIDTH-1:0]      cnt_ok,
    output logic [CNT_WIDTH-1:0]      cnt_corr,
    output logic [CNT_WIDTH-1:0]      cnt_uncorr
);
    localparam int EW = entry_width(DATA_WIDTH);

    logic          done_d;
    logic          capture;
    logic          push_ok;
    logic [EW-1:0] head;

    // A level held high on done_in yields exactly one capture.
    assign capture = done_in & ~done_d;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (capture),
        .pop     (rd.rd_ready),
        .wr_data ({data_in, nof_in}),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .push_ok (push_ok)
    );

    assign rd.rd_valid = ~empty;
    assign rd.rd_data  = head[EW-1:2];
    assign rd.rd_nof   = head[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            done_d <= 1'b0;
        end else begin
            done_d <= done_in;
        end
    end

    // Statistics count every capture, dropped or not; clr_stats wins.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            overflow   <= 1'b0;
            cnt_ok     <= '0;
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (capture) begin
            if (!push_ok) overflow <= 1'b1;
            if (nof_in == NOF_NONE) begin
                if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
            end else if (nof_in == NOF_SINGLE) begin
                if (cnt_corr != '1) cnt_corr <= cnt_corr + 1'b1;
            end else if (nof_in >= NOF_DOUBLE) begin
                if (cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_result_fifo.sv
// Directed bench for ecc_result_fifo (DEPTH=4, CNT_WIDTH=2 so counter
// saturation at 3 is reachable with few captures).
module tb_ecc_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [31:0] data_in;
    logic [1:0]  nof_in;
    logic        clr_stats;
    logic [2:0]  level;
    logic        full, empty, overflow;
    logic [1:0]  cnt_ok, cnt_corr, cnt_uncorr;

    int checks = 0;
    int errors = 0;

    ecc_result_fifo_if #(.DATA_WIDTH(32)) rd_if ();

    ecc_result_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .CNT_WIDTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .done_in    (done_in),
        .data_in    (data_in),
        .nof_in     (nof_in),
        .clr_stats  (clr_stats),
        .rd         (rd_if),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .cnt_ok     (cnt_ok),
        .cnt_corr   (cnt_corr),
        .cnt_uncorr (cnt_uncorr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, done;
        logic [31:0] data;
        logic [1:0]  nof;
        logic        clr, rdy;
        logic        valid;
        logic [31:0] q;
        logic [1:0]  qnof;
        logic [2:0]  lvl;
        logic        full, empty, ovf;
        logic [1:0]  ok, corr, unc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(
        input logic r, input logic d, input logic [31:0] dat, input logic [1:0] n,
        input logic c, input logic rdy, input logic v, input logic [31:0] q,
        input logic [1:0] qn, input logic [2:0] l, input logic f, input logic e,
        input logic o, input logic [1:0] ok, input logic [1:0] co, input logic [1:0] un);
        vec_t t;
        t.rst = r; t.done = d; t.data = dat; t.nof = n; t.clr = c; t.rdy = rdy;
        t.valid = v; t.q = q; t.qnof = qn; t.lvl = l; t.full = f; t.empty = e;
        t.ovf = o; t.ok = ok; t.corr = co; t.unc = un;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic [31:0] dat,
                         input logic [1:0] n, input logic c, input logic rdy);
        rst = r; done_in = d; data_in = dat; nof_in = n; clr_stats = c;
        rd_if.rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] q,
                             input logic [1:0] qn, input logic [2:0] l, input logic f,
                             input logic e, input logic o, input logic [1:0] ok,
                             input logic [1:0] co, input logic [1:0] un);
        chk({tag, ".rd_valid"},   32'(rd_if.rd_valid), 32'(v));
        chk({tag, ".rd_data"},    rd_if.rd_data,       q);
        chk({tag, ".rd_nof"},     32'(rd_if.rd_nof),   32'(qn));
        chk({tag, ".level"},      32'(level),          32'(l));
        chk({tag, ".full"},       32'(full),           32'(f));
        chk({tag, ".empty"},      32'(empty),          32'(e));
        chk({tag, ".overflow"},   32'(overflow),       32'(o));
        chk({tag, ".cnt_ok"},     32'(cnt_ok),         32'(ok));
        chk({tag, ".cnt_corr"},   32'(cnt_corr),       32'(co));
        chk({tag, ".cnt_uncorr"}, 32'(cnt_uncorr),     32'(un));
    endtask

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    initial begin
        logic [1:0]  m_ok, m_corr, m_unc;
        logic [1:0]  n;
        logic [31:0] d;

        //           rst dn data          nof clr rdy | v  q             qn lvl f e o ok co un
        vecs[0]  = mk(1, 0, 32'h0,        0,  0,  0,    0, 32'h0,        0, 0, 0,1,0, 0, 0, 0);
        // single capture, done held 3 cycles
        vecs[1]  = mk(0, 1, 32'hDEADBEEF, 1,  0,  0,    1, 32'hDEADBEEF, 1, 1, 0,0,0, 0, 1, 0);
        vecs[2]  = mk(0, 1, 32'hDEADBEEF, 1,  0,  0,    1, 32'hDEADBEEF, 1, 1, 0,0,0, 0, 1, 0);
        vecs[3]  = mk(0, 1, 32'hDEADBEEF, 1,  0,  0,    1, 32'hDEADBEEF, 1, 1, 0,0,0, 0, 1, 0);
        vecs[4]  = mk(0, 0, 32'h0,        0,  0,  1,    0, 32'h0,        0, 0, 0,1,0, 0, 1, 0);
        // fill with 5 nof=0 captures: 5th dropped, cnt_ok saturates at 3
        vecs[5]  = mk(0, 1, 32'h1,        0,  0,  0,    1, 32'h1,        0, 1, 0,0,0, 1, 1, 0);
        vecs[6]  = mk(0, 0, 32'h1,        0,  0,  0,    1, 32'h1,        0, 1, 0,0,0, 1, 1, 0);
        vecs[7]  = mk(0, 1, 32'h2,        0,  0,  0,    1, 32'h1,        0, 2, 0,0,0, 2, 1, 0);
        vecs[8]  = mk(0, 0, 32'h2,        0,  0,  0,    1, 32'h1,        0, 2, 0,0,0, 2, 1, 0);
        vecs[9]  = mk(0, 1, 32'h3,        0,  0,  0,    1, 32'h1,        0, 3, 0,0,0, 3, 1, 0);
        vecs[10] = mk(0, 0, 32'h3,        0,  0,  0,    1, 32'h1,        0, 3, 0,0,0, 3, 1, 0);
        vecs[11] = mk(0, 1, 32'h4,        0,  0,  0,    1, 32'h1,        0, 4, 1,0,0, 3, 1, 0);
        vecs[12] = mk(0, 0, 32'h4,        0,  0,  0,    1, 32'h1,        0, 4, 1,0,0, 3, 1, 0);
        vecs[13] = mk(0, 1, 32'h5,        0,  0,  0,    1, 32'h1,        0, 4, 1,0,1, 3, 1, 0);
        vecs[14] = mk(0, 0, 32'h5,        0,  0,  0,    1, 32'h1,        0, 4, 1,0,1, 3, 1, 0);
        // clear stats, then push+pop while full
        vecs[15] = mk(0, 0, 32'h0,        0,  1,  0,    1, 32'h1,        0, 4, 1,0,0, 0, 0, 0);
        vecs[16] = mk(0, 1, 32'h6,        2,  0,  1,    1, 32'h2,        0, 4, 1,0,0, 0, 0, 1);
        vecs[17] = mk(0, 0, 32'h0,        0,  0,  1,    1, 32'h3,        0, 3, 0,0,0, 0, 0, 1);
        vecs[18] = mk(0, 0, 32'h0,        0,  0,  1,    1, 32'h4,        0, 2, 0,0,0, 0, 0, 1);
        vecs[19] = mk(0, 0, 32'h0,        0,  0,  1,    1, 32'h6,        2, 1, 0,0,0, 0, 0, 1);
        vecs[20] = mk(0, 0, 32'h0,        0,  0,  1,    0, 32'h0,        0, 0, 0,1,0, 0, 0, 1);
        // clr_stats with a same-cycle nof=2 capture: entry queued, counter cleared
        vecs[21] = mk(0, 1, 32'h7,        2,  1,  0,    1, 32'h7,        2, 1, 0,0,0, 0, 0, 0);
        vecs[22] = mk(0, 0, 32'h0,        0,  0,  1,    0, 32'h0,        0, 0, 0,1,0, 0, 0, 0);

        rst = 1'b1; done_in = 1'b0; data_in = '0; nof_in = '0; clr_stats = 1'b0;
        rd_if.rd_ready = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].done, vecs[i].data, vecs[i].nof, vecs[i].clr, vecs[i].rdy);
            chk_state($sformatf("vec%0d", i), vecs[i].valid, vecs[i].q, vecs[i].qnof,
                      vecs[i].lvl, vecs[i].full, vecs[i].empty, vecs[i].ovf,
                      vecs[i].ok, vecs[i].corr, vecs[i].unc);
        end

        // Wrap-around: 10 push/pop pairs, pointers cross the DEPTH boundary.
        m_ok = '0; m_corr = '0; m_unc = '0;
        for (int k = 0; k < 10; k++) begin
            n = 2'(k % 4);
            d = 32'hA5000000 + 32'(k);
            if (n == 2'd0) m_ok = sat_inc(m_ok);
            else if (n == 2'd1) m_corr = sat_inc(m_corr);
            else m_unc = sat_inc(m_unc);
            drive(0, 1, d, n, 0, 0);
            chk_state($sformatf("wrap%0d.push", k), 1, d, n, 1, 0, 0, 0, m_ok, m_corr, m_unc);
            drive(0, 0, 32'h0, 0, 0, 1);
            chk_state($sformatf("wrap%0d.pop", k), 0, 32'h0, 0, 0, 0, 1, 0, m_ok, m_corr, m_unc);
        end

        // Reset mid-operation with done_in held high across release.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'hC0 + 32'(k), 1, 0, 0);
            drive(0, 0, 32'h0, 0, 0, 0);
        end
        chk("pre_reset.level", 32'(level), 32'd3);
        drive(1, 1, 32'hBEEF0001, 1, 0, 0);
        chk_state("reset", 0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 32'hBEEF0001, 1, 0, 0);
        chk_state("post_rst1", 1, 32'hBEEF0001, 1, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 32'hBEEF0002, 2, 0, 0);
        chk_state("post_rst2", 1, 32'hBEEF0001, 1, 1, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 32'h0, 0, 0, 1);
        chk_state("post_rst3", 0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
